led_status_sequencer: RTL

Schedules the single board status LED between four status requesters (link, video lock, FIFO error, heartbeat-class sources). The block arbitrates by fixed priority and plays the granted requester's blink code: N pulses followed by a gap. It replaces free-running toggle indicators wherever more than one condition must share one LED. It contains its own tick timebase and sits beside the top-level LED pin driver.

---
 rtl/led_status_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/led_status_sequencer.sv
// Shares one status LED between four requesters: fixed-priority arbitration,
// then the winner's blink code (N pulses, then a gap) on a divided tick timebase.
module led_status_sequencer #(
    parameter int unsigned TICK_DIV  = 5_000_000,
    parameter int unsigned ON_TICKS  = 2,
    parameter int unsigned OFF_TICKS = 3,
    parameter int unsigned GAP_TICKS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] code,
    output logic        led,
    output logic        busy,
    output logic [1:0]  grant_id,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

    localparam logic [31:0] DIV_LAST = 32'(TICK_DIV - 1);
    localparam logic [7:0]  ON_LAST  = 8'(ON_TICKS - 1);
    localparam logic [7:0]  OFF_LAST = 8'(OFF_TICKS - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_TICKS - 1);

    state_t      state_q, state_d;
    logic [31:0] div_q, div_d;
    logic [7:0]  ph_q, ph_d;
    logic [3:0]  pulses_q, pulses_d;
    logic        led_q, led_d;
    logic [1:0]  grant_q, grant_d;
    logic        done_q, done_d;

    logic        tick;
    logic [3:0]  elig;
    logic        any_elig;
    logic [1:0]  win_id;
    logic [3:0]  win_code;
    logic        grant_now;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? 32'd0 : div_q + 32'd1;
    end

    // A zero code masks its requester even while req is high.
    always_comb begin
        elig[0] = req[0] && (code[3:0]   != 4'd0);
        elig[1] = req[1] && (code[7:4]   != 4'd0);
        elig[2] = req[2] && (code[11:8]  != 4'd0);
        elig[3] = req[3] && (code[15:12] != 4'd0);
        any_elig = |elig;
        win_id   = 2'd0;
        win_code = 4'd0;
        if (elig[0]) begin
            win_id   = 2'd0;
            win_code = code[3:0];
        end else if (elig[1]) begin
            win_id   = 2'd1;
            win_code = code[7:4];
        end else if (elig[2]) begin
            win_id   = 2'd2;
            win_code = code[11:8];
        end else if (elig[3]) begin
            win_id   = 2'd3;
            win_code = code[15:12];
        end
    end

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        pulses_d  = pulses_q;
        led_d     = led_q;
        grant_d   = grant_q;
        done_d    = 1'b0;
        grant_now = 1'b0;
        if (tick) begin
            case (state_q)
                S_IDLE: grant_now = any_elig;
                S_ON: begin
                    if (ph_q == ON_LAST) begin
                        led_d    = 1'b0;
                        pulses_d = pulses_q - 4'd1;
                        ph_d     = 8'd0;
                        state_d  = S_OFF;
                    end else begin
                        ph_d = ph_q + 8'd1;
                    end
                end
                S_OFF: begin
                    if (ph_q == OFF_LAST) begin
                        ph_d = 8'd0;
                        if (pulses_q == 4'd0) begin
                            state_d = S_GAP;
                        end else begin
                            led_d   = 1'b1;
                            state_d = S_ON;
                        end
                    end else begin
                        ph_d = ph_q + 8'd1;
                    end
                end
                S_GAP: begin
                    // Re-arbitrate on the closing tick so codes run back to back.
                    if (ph_q == GAP_LAST) begin
                        done_d    = 1'b1;
                        ph_d      = 8'd0;
                        grant_now = any_elig;
                        if (!any_elig) state_d = S_IDLE;
                    end else begin
                        ph_d = ph_q + 8'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (grant_now) begin
            state_d  = S_ON;
            grant_d  = win_id;
            pulses_d = win_code;
            ph_d     = 8'd0;
            led_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            div_q    <= 32'd0;
            ph_q     <= 8'd0;
            pulses_q <= 4'd0;
            led_q    <= 1'b0;
            grant_q  <= 2'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            ph_q     <= ph_d;
            pulses_q <= pulses_d;
            led_q    <= led_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
        end
    end

    assign led      = led_q;
    assign busy     = (state_q != S_IDLE);
    assign grant_id = grant_q;
    assign done     = done_q;

endmodule
